// File: rtl/offchip_pkg.sv
// Shared constants, state encoding and flit helpers for the off-chip TX serializer.
package offchip_pkg;

   localparam int unsigned DATA_W  = 64;
   localparam int unsigned FLIT_W  = 16;
   localparam int unsigned FLITS   = DATA_W / FLIT_W;
   localparam int unsigned CREDITS = 8;
   localparam int unsigned CNT_W   = $clog2(CREDITS + 1);
   localparam int unsigned IDX_W   = $clog2(FLITS);

   typedef enum logic {
      IDLE,
      SEND
   } tx_state_e;

   typedef struct packed {
      logic [FLIT_W-1:0] data;
      logic              sof;
      logic              eof;
   } flit_t;

   // Flit k of a beat is bits [16k+15:16k]; flits leave LSB first.
   function automatic logic [FLIT_W-1:0] flit_sel(input logic [DATA_W-1:0] beat,
                                                  input logic [IDX_W-1:0]  idx);
      return beat[32'(idx) * FLIT_W +: FLIT_W];
   endfunction

endpackage

// File: rtl/offchip_credit_counter.sv
// Link credit counter: one credit consumed per flit sent, one returned per pulse,
// saturating at CREDITS with a sticky overflow flag.
module offchip_credit_counter #(
   parameter  int unsigned CREDITS = 8,
   localparam int unsigned CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             consume,
   input  logic             ret,
   output logic [CNT_W-1:0] cnt,
   output logic             avail,
   output logic             ovf_sticky
);

   logic [CNT_W-1:0] cnt_next;
   logic             ovf_set;

   // consume is only asserted while avail, so the count never underflows.
   always_comb begin
      cnt_next = cnt;
      ovf_set  = 1'b0;
      case ({consume, ret})
         2'b10:   cnt_next = cnt - CNT_W'(1);
         2'b01: begin
            if (cnt == CNT_W'(CREDITS)) ovf_set  = 1'b1;
            else                        cnt_next = cnt + CNT_W'(1);
         end
         default: cnt_next = cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= CNT_W'(CREDITS);
         ovf_sticky <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         ovf_sticky <= ovf_sticky | ovf_set;
      end
   end

   assign avail = (cnt != '0);

endmodule

// File: rtl/offchip_tx_serializer.sv
// Serializes 64-bit valid/ready beats into 16-bit pad-link flits under credit flow control.
module offchip_tx_serializer
   import offchip_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [FLIT_W-1:0] phy_data,
   output logic              phy_valid,
   output logic              phy_sof,
   output logic              phy_eof,
   input  logic              phy_credit,
   output logic [CNT_W-1:0]  credit_cnt,
   output logic              err_credit_ovf
);

   tx_state_e         state, state_next;
   logic [IDX_W-1:0]  idx, idx_next;
   logic [DATA_W-1:0] hold, hold_next;
   flit_t             flit_q, flit_next;
   logic              valid_next;
   logic              avail;
   logic              send;
   logic              last;

   assign send = (state == SEND) && avail;
   assign last = (idx == IDX_W'(FLITS - 1));

   offchip_credit_counter #(.CREDITS(CREDITS)) u_credit (
      .clk        (clk),
      .rst_n      (rst_n),
      .consume    (send),
      .ret        (phy_credit),
      .cnt        (credit_cnt),
      .avail      (avail),
      .ovf_sticky (err_credit_ovf)
   );

   // Next state, beat loading and flit emission; a stall keeps idx so no flit is lost or repeated.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      hold_next  = hold;
      flit_next  = flit_q;
      valid_next = 1'b0;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               hold_next  = in_data;
               idx_next   = '0;
               state_next = SEND;
            end
         end
         SEND: begin
            if (send) begin
               flit_next.data = flit_sel(hold, idx);
               flit_next.sof  = (idx == '0);
               flit_next.eof  = last;
               valid_next     = 1'b1;
               idx_next       = idx + IDX_W'(1);
               if (last) begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     hold_next = in_data;
                     idx_next  = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         hold      <= '0;
         flit_q    <= '0;
         phy_valid <= 1'b0;
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         hold      <= hold_next;
         flit_q    <= flit_next;
         phy_valid <= valid_next;
      end
   end

   assign phy_data = flit_q.data;
   assign phy_sof  = flit_q.sof & phy_valid;
   assign phy_eof  = flit_q.eof & phy_valid;

endmodule

// File: tb/tb_offchip_tx_serializer.sv
// Scoreboard bench for offchip_tx_serializer: directed beats, credit scenarios, async reset.
module tb_offchip_tx_serializer;
   import offchip_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [FLIT_W-1:0] phy_data;
   logic              phy_valid;
   logic              phy_sof;
   logic              phy_eof;
   logic              phy_credit;
   logic [CNT_W-1:0]  credit_cnt;
   logic              err_credit_ovf;

   int errors = 0;
   int checks = 0;
   int nflits = 0;
   int base;
   logic [17:0] exp_q[$];

   offchip_tx_serializer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .phy_data       (phy_data),
      .phy_valid      (phy_valid),
      .phy_sof        (phy_sof),
      .phy_eof        (phy_eof),
      .phy_credit     (phy_credit),
      .credit_cnt     (credit_cnt),
      .err_credit_ovf (err_credit_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_beat(input logic [15:0] f0, input logic [15:0] f1,
                            input logic [15:0] f2, input logic [15:0] f3);
      exp_q.push_back({f0, 1'b1, 1'b0});
      exp_q.push_back({f1, 1'b0, 1'b0});
      exp_q.push_back({f2, 1'b0, 1'b0});
      exp_q.push_back({f3, 1'b0, 1'b1});
   endtask

   // Presents a beat and returns #1 after the accepting edge with in_valid still high.
   task automatic accept(input logic [DATA_W-1:0] d);
      bit done = 0;
      in_data  = d;
      in_valid = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL accept_timeout: got no in_ready expected in_ready=1 for beat %0h", d);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every presented flit must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && phy_valid) begin
         nflits++;
         if (exp_q.size() == 0) begin
            chk("unexpected_flit", {46'h0, phy_data, phy_sof, phy_eof}, 64'h0);
         end else begin
            chk("flit", {46'h0, phy_data, phy_sof, phy_eof}, {46'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      in_data    = '0;
      in_valid   = 1'b0;
      phy_credit = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick(1);

      // 1: reset state
      chk("rst_credit_cnt", 64'(credit_cnt), 64'd8);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_phy_valid", 64'(phy_valid), 64'd0);
      chk("rst_ovf", 64'(err_credit_ovf), 64'd0);

      // 2: single beat, ample credits
      base = nflits;
      push_beat(16'h6677, 16'h4455, 16'h2233, 16'h0011);
      accept(64'h0011_2233_4455_6677);
      in_valid = 1'b0;
      tick(5);
      chk("t2_flit_count", 64'(nflits - base), 64'd4);
      chk("t2_credit_cnt", 64'(credit_cnt), 64'd4);
      chk("t2_phy_valid_idle", 64'(phy_valid), 64'd0);
      phy_credit = 1'b1;
      tick(4);
      phy_credit = 1'b0;
      chk("t2_refill", 64'(credit_cnt), 64'd8);

      // 3: back-to-back beats, credit returned on every send edge
      base = nflits;
      push_beat(16'h2211, 16'h4433, 16'h6655, 16'h8877);
      push_beat(16'h9988, 16'hBBAA, 16'hDDCC, 16'hFFEE);
      accept(64'h8877_6655_4433_2211);
      in_data    = 64'hFFEE_DDCC_BBAA_9988;
      phy_credit = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         if (i == 4) chk("t3_in_ready_last", 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;
         if (i == 4) in_valid = 1'b0;
         chk("t3_contig_valid", 64'(phy_valid), 64'd1);
         chk("t3_credit_cnt", 64'(credit_cnt), 64'd8);
      end
      phy_credit = 1'b0;
      tick(1);
      chk("t3_valid_after", 64'(phy_valid), 64'd0);
      chk("t3_flit_count", 64'(nflits - base), 64'd8);
      chk("t3_credit_after", 64'(credit_cnt), 64'd8);

      // 4: three beats, no credit returns -> stall after 8 flits
      base = nflits;
      push_beat(16'h0708, 16'h0506, 16'h0304, 16'h0102);
      push_beat(16'hD1D2, 16'hC1C2, 16'hB1B2, 16'hA1A2);
      push_beat(16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD);
      accept(64'h0102_0304_0506_0708);
      accept(64'hA1A2_B1B2_C1C2_D1D2);
      accept(64'hDEAD_BEEF_CAFE_F00D);
      in_valid = 1'b0;
      tick(2);
      chk("t4_stall_valid", 64'(phy_valid), 64'd0);
      chk("t4_stall_in_ready", 64'(in_ready), 64'd0);
      chk("t4_stall_credit", 64'(credit_cnt), 64'd0);
      chk("t4_flit_count8", 64'(nflits - base), 64'd8);
      phy_credit = 1'b1;
      tick(1);
      phy_credit = 1'b0;
      chk("t4_no_same_edge_send", 64'(phy_valid), 64'd0);
      chk("t4_credit_one", 64'(credit_cnt), 64'd1);
      tick(1);
      chk("t4_ninth_valid", 64'(phy_valid), 64'd1);
      chk("t4_ninth_data", 64'(phy_data), 64'hF00D);
      tick(1);
      chk("t4_single_flit", 64'(phy_valid), 64'd0);
      chk("t4_flit_count9", 64'(nflits - base), 64'd9);
      phy_credit = 1'b1;
      tick(11);
      phy_credit = 1'b0;
      tick(1);
      chk("t4_drained", 64'(exp_q.size()), 64'd0);
      chk("t4_refill", 64'(credit_cnt), 64'd8);
      chk("t4_no_ovf", 64'(err_credit_ovf), 64'd0);

      // 5: credit return while full -> saturate and sticky overflow
      phy_credit = 1'b1;
      tick(1);
      phy_credit = 1'b0;
      chk("t5_saturate", 64'(credit_cnt), 64'd8);
      chk("t5_ovf_set", 64'(err_credit_ovf), 64'd1);
      tick(3);
      chk("t5_ovf_sticky", 64'(err_credit_ovf), 64'd1);

      // 6: async reset right after flit 1 drops the rest of the beat
      base = nflits;
      exp_q.push_back({16'hDEF0, 1'b1, 1'b0});
      exp_q.push_back({16'h9ABC, 1'b0, 1'b0});
      accept(64'h1234_5678_9ABC_DEF0);
      in_valid = 1'b0;
      tick(2);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(phy_valid), 64'd0);
      chk("t6_rst_credit", 64'(credit_cnt), 64'd8);
      chk("t6_rst_ovf", 64'(err_credit_ovf), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(8);
      chk("t6_flit_count", 64'(nflits - base), 64'd2);
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
